// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider used by EX for DIV/DIVU.
// Returns {remainder, quotient} on result_o with ready_o; operands are held
// by EX while start_i is high and are only sampled while the unit is FREE.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   signed_div_i    1 = two's complement divide, 0 = unsigned
//   opdata1_i       dividend
//   opdata2_i       divisor
//   start_i         request, held until ready_o is seen
//   annul_i         cancel the in-flight division
//   result_o        {remainder, quotient}, registered
//   ready_o         result_o valid, registered
module div_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned WORK_W = 2 * DATA_W + 1;
    localparam int unsigned DIFF_W = DATA_W + 2;

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]            state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [WORK_W-1:0]     work_q,   work_d;
    logic [DATA_W-1:0]     dvsr_q,   dvsr_d;
    logic                  sign_a_q, sign_a_d;
    logic                  sign_b_q, sign_b_d;
    logic                  sgn_q,    sgn_d;
    logic [2*DATA_W-1:0]   result_d;
    logic                  ready_d;

    // Operand magnitudes as presented at the ports
    logic [DATA_W-1:0]     abs1_c, abs2_c;
    // One restoring iteration on the current work register
    logic [WORK_W-1:0]     shifted_c;
    logic [DIFF_W-1:0]     diff_c;
    logic [WORK_W-1:0]     work_iter_c;
    // Sign-corrected final values
    logic [DATA_W-1:0]     quot_c, rem_c, quot_fix_c, rem_fix_c;

    always_comb begin
        abs1_c = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        abs2_c = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

        shifted_c = work_q << 1;
        diff_c    = {1'b0, shifted_c[WORK_W-1:DATA_W]} - {2'b00, dvsr_q};
        // Negative trial difference means restore (keep the shifted value, LSB 0)
        if (diff_c[DIFF_W-1]) begin
            work_iter_c = shifted_c;
        end else begin
            work_iter_c = {diff_c[DATA_W:0], shifted_c[DATA_W-1:1], 1'b1};
        end

        quot_c     = work_q[DATA_W-1:0];
        rem_c      = work_q[2*DATA_W-1:DATA_W];
        quot_fix_c = (sgn_q && (sign_a_q ^ sign_b_q)) ? -quot_c : quot_c;
        rem_fix_c  = (sgn_q && sign_a_q) ? -rem_c : rem_c;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvsr_d   = dvsr_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        sgn_d    = sgn_q;
        result_d = result_o;
        ready_d  = ready_o;

        case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d  = S_ON;
                        dvsr_d   = abs2_c;
                        sign_a_d = opdata1_i[DATA_W-1];
                        sign_b_d = opdata2_i[DATA_W-1];
                        sgn_d    = signed_div_i;
                        cnt_d    = '0;
                        work_d   = {{(DATA_W+1){1'b0}}, abs1_c};
                    end
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    work_d = work_iter_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {rem_fix_c, quot_fix_c};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end
            S_END: begin
                // Result is held only while EX keeps the request up
                if (!start_i || annul_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = S_FREE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sgn_q    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvsr_q   <= dvsr_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            sgn_q    <= sgn_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule
